// File: rtl/uart_in_responder_pkg.sv
// Shared constants and types for the UART input responder: the idle character
// returned when nothing is deliverable, and the statistics counter widths.
package uart_in_responder_pkg;

    localparam logic [7:0] UART_NO_DATA    = 8'hFF;
    localparam int         DELIVERED_CNT_W = 32;
    localparam int         OVERFLOW_CNT_W  = 16;

    typedef logic [7:0] uart_char_t;

endpackage

// File: rtl/uart_in_fifo.sv
// Character FIFO with wrap-bit pointers; the head entry is readable combinationally.
// Callers never push while full or pop while empty; flush outranks push and pop.
module uart_in_fifo
    import uart_in_responder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  uart_char_t             push_data,
    input  logic                   pop,
    input  logic                   flush,
    output uart_char_t             head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    uart_char_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; empty pointers make stale entries unobservable.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/uart_in_responder.sv
// Answers the DUT's per-cycle UART read requests from a host-fed FIFO, with
// optional idle pacing between characters and delivery/overflow statistics.
module uart_in_responder
    import uart_in_responder_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       difftest_uart_in_valid,
    output uart_char_t                 difftest_uart_in_ch,
    input  logic                       host_wvalid,
    input  uart_char_t                 host_wdata,
    output logic                       host_wready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DELIVERED_CNT_W-1:0] delivered_cnt,
    output logic [OVERFLOW_CNT_W-1:0]  overflow_cnt
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    uart_char_t       head;
    logic             empty;
    logic             full;
    logic             avail;
    logic             push;
    logic             pop;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_next;

    uart_in_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (host_wdata),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    // No bypass: a character written into an empty FIFO is visible one cycle later.
    assign avail               = !empty && (gap_cnt == '0);
    assign difftest_uart_in_ch = avail ? head : UART_NO_DATA;
    assign host_wready         = !full;
    assign push                = host_wvalid && !full && !flush;
    assign pop                 = difftest_uart_in_valid && avail && !flush;

    // NOTE: assign the default first so every path drives gap_next and no latch is inferred.
    always_comb begin
        gap_next = gap_cnt;
        if (flush) begin
            gap_next = '0;
        end else if (pop) begin
            gap_next = GAP_W'(GAP_CYCLES);
        end else if (gap_cnt != '0) begin
            gap_next = gap_cnt - GAP_W'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt       <= '0;
            delivered_cnt <= '0;
            overflow_cnt  <= '0;
        end else begin
            gap_cnt <= gap_next;
            if (pop) begin
                delivered_cnt <= delivered_cnt + DELIVERED_CNT_W'(1);
            end
            if (host_wvalid && full && !flush && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + OVERFLOW_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/uart_in_responder.md
UART_IN_RESPONDER -- requirements
Module: uart_in_responder

Interface
REQ-001 Parameters: DEPTH, 16, FIFO entries (power of two, at least 2).
REQ-002 Parameters: GAP_CYCLES, 0, minimum idle cycles after each delivered character (baud pacing; 0 = back-to-back).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 difftest_uart_in_valid  input  1  DUT read request, one character per asserted cycle.
REQ-006 difftest_uart_in_ch  output  8  response character; 8'hFF = no data.
REQ-007 host_wvalid  input  1  host offers a character.
REQ-008 host_wdata  input  8  character offered by host.
REQ-009 host_wready  output  1  FIFO can accept a character.
REQ-010 flush  input  1  synchronous discard of all buffered characters.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 delivered_cnt  output  32  characters handed to DUT.
REQ-013 overflow_cnt  output  16  host offers refused while full.

Function
REQ-014 FIFO shall use read/write pointers of $clog2(DEPTH)+1 bits; empty = pointers equal; full = indices equal, wrap bits differ.
REQ-015 host_wready shall equal !full, combinationally.
REQ-016 A write shall occur when host_wvalid && host_wready; host_wdata is stored at the write index and the write pointer increments, wrapping modulo 2*DEPTH.
REQ-017 avail shall equal !empty && (gap_cnt == 0).
REQ-018 difftest_uart_in_ch shall equal the head entry when avail, else 8'hFF, combinationally and same-cycle (zero latency).
REQ-019 A pop shall occur when difftest_uart_in_valid && avail: read pointer increments, delivered_cnt increments (wraps at 2^32), gap_cnt loads GAP_CYCLES.
REQ-020 gap_cnt shall decrement by 1 per cycle while nonzero and no pop occurs.
REQ-021 A request with avail low shall receive 8'hFF and change no state.
REQ-022 When empty, a same-cycle write and request shall return 8'hFF; no bypass; the character becomes available the next cycle.
REQ-023 When full, a same-cycle pop and write offer: the pop proceeds; the write is refused (host_wready low); overflow_cnt increments.
REQ-024 overflow_cnt shall increment on host_wvalid && full and saturate at 16'hFFFF.
REQ-025 level shall equal write pointer minus read pointer, modulo 2^($clog2(DEPTH)+1).
REQ-026 flush shall set read pointer equal to write pointer and clear gap_cnt; it takes priority over a same-cycle write and pop.
REQ-027 During a flush cycle, difftest_uart_in_ch still reflects the pre-flush state, but no pop or count update occurs.
REQ-028 flush shall not clear delivered_cnt or overflow_cnt.

Reset
REQ-029 Reset shall asynchronously clear pointers, gap_cnt, delivered_cnt and overflow_cnt.
REQ-030 Outputs during and after reset: level=0, host_wready=1, difftest_uart_in_ch=8'hFF.
REQ-031 FIFO storage shall not be reset; contents are unobservable while empty.
REQ-032 Reset asserted mid-operation shall discard all buffered data with no partial delivery.

Structure
REQ-033 A shared package shall hold UART_NO_DATA = 8'hFF and the counter widths 32 and 16.
REQ-034 Storage and pointers shall form one sub-module, uart_in_fifo (push, pop, flush, head, empty, full, level); pacing and counters stay in the top.

Verification
REQ-035 Reset, then request every cycle with no writes -> ch=8'hFF, delivered_cnt=0, level=0.
REQ-036 GAP_CYCLES=0: write 'A','B','C', then request 3 consecutive cycles -> ch 'A','B','C' in order, then 8'hFF; delivered_cnt=3.
REQ-037 GAP_CYCLES=3: two characters buffered, request held high -> deliveries 4 cycles apart; ch=8'hFF during the 3 gap cycles.
REQ-038 DEPTH=16: write 18 characters with no requests -> level=16, host_wready=0, overflow_cnt=2; then drain 16 -> first 16 values in order.
REQ-039 Full FIFO, same cycle host_wvalid and request -> head delivered, write refused, level=15, overflow_cnt+1.
REQ-040 Buffer 5, deliver 2, pulse flush together with a request and a write -> level=0, delivered_cnt=2; next request returns 8'hFF; async reset mid-gap -> all counters 0.
